// File: rtl/m68k_bus_master.sv
// 68000-style asynchronous bus master: S0..S7 bus cycle paced by cpu_ce, DTACK wait states, BR/BG/BGACK arbitration.
// Optional DTACK timeout (8-bit wait counter, err flag, read data forced to FFFF) enabled by defining M68K_BUS_TIMEOUT_EN.
module m68k_bus_master (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        cpu_ce,
  input  logic        req,
  input  logic [22:0] req_addr,
  input  logic        req_we,
  input  logic        req_uds,
  input  logic        req_lds,
  input  logic [1:0]  req_fc,
  input  logic [15:0] req_wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [22:0] VA_o,
  output logic        VA_d,
  input  logic [15:0] VD_i,
  output logic [15:0] VD_o,
  output logic        VD_d,
  output logic        AS_o,
  output logic        UDS_o,
  output logic        LDS_o,
  output logic        RW_o,
  output logic        strobe_d,
  output logic        FC0,
  output logic        FC1,
  input  logic        DTACK_i,
  input  logic        BR_i,
  input  logic        BGACK_i,
  output logic        BG
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 23;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_S0    = 4'd1;
  localparam logic [3:0] ST_S1    = 4'd2;
  localparam logic [3:0] ST_S2    = 4'd3;
  localparam logic [3:0] ST_S3    = 4'd4;
  localparam logic [3:0] ST_S4    = 4'd5;
  localparam logic [3:0] ST_S5    = 4'd6;
  localparam logic [3:0] ST_S6    = 4'd7;
  localparam logic [3:0] ST_S7    = 4'd8;
  localparam logic [3:0] ST_GRANT = 4'd9;
  localparam logic [3:0] ST_OWNED = 4'd10;

  logic [3:0]    state_q, state_d;
  logic          we_q, uds_q, lds_q;
  logic [DW-1:0] wdata_q;
  logic          wait_half_q;
  logic          sample_c, timeout_c, timeout_q;
  logic          start_c, done_c;
  logic          in_cycle_c, as_act_c, ds_act_c, rw_act_c, vd_act_c, bus_rel_c;

  // Next state; S4 samples DTACK only on every other cpu_ce so each wait costs two pulses
  always_comb begin
    state_d  = state_q;
    sample_c = 1'b0;
    if (cpu_ce) begin
      case (state_q)
        ST_IDLE: begin
          if (!BR_i)    state_d = ST_GRANT;
          else if (req) state_d = ST_S0;
        end
        ST_S0, ST_S1, ST_S2, ST_S3, ST_S5, ST_S6: state_d = state_q + 4'd1;
        ST_S4: begin
          if (!wait_half_q) begin
            sample_c = 1'b1;
            if (!DTACK_i || timeout_c) state_d = ST_S5;
          end
        end
        ST_S7:    state_d = ST_IDLE;
        ST_GRANT: begin
          if (!BGACK_i)  state_d = ST_OWNED;
          else if (BR_i) state_d = ST_IDLE;
        end
        ST_OWNED: if (BGACK_i && BR_i) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Bus pin activity decoded from the upcoming state so the registered pins line up with it
  always_comb begin
    start_c    = (state_q == ST_IDLE) && (state_d == ST_S0);
    done_c     = (state_q == ST_S7) && (state_d == ST_IDLE);
    in_cycle_c = (state_d >= ST_S0) && (state_d <= ST_S7);
    as_act_c   = (state_d >= ST_S2) && (state_d <= ST_S6);
    ds_act_c   = we_q ? ((state_d >= ST_S4) && (state_d <= ST_S6)) : as_act_c;
    rw_act_c   = we_q && (state_d >= ST_S2) && (state_d <= ST_S7);
    vd_act_c   = we_q && (state_d >= ST_S3) && (state_d <= ST_S7);
    bus_rel_c  = (state_d == ST_GRANT) || (state_d == ST_OWNED);
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      ack         <= 1'b0;
      busy        <= 1'b0;
      BG          <= 1'b1;
      strobe_d    <= 1'b0;
      VA_o        <= '0;
      VA_d        <= 1'b1;
      FC0         <= 1'b0;
      FC1         <= 1'b0;
      AS_o        <= 1'b1;
      UDS_o       <= 1'b1;
      LDS_o       <= 1'b1;
      RW_o        <= 1'b1;
      VD_o        <= '0;
      VD_d        <= 1'b1;
      rdata       <= '0;
      we_q        <= 1'b0;
      uds_q       <= 1'b0;
      lds_q       <= 1'b0;
      wdata_q     <= '0;
      wait_half_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack      <= done_c;
      busy     <= (state_d != ST_IDLE);
      BG       <= !bus_rel_c;
      strobe_d <= bus_rel_c;
      VA_d     <= !in_cycle_c;
      AS_o     <= !as_act_c;
      UDS_o    <= !(ds_act_c && uds_q);
      LDS_o    <= !(ds_act_c && lds_q);
      RW_o     <= !rw_act_c;
      VD_d     <= !vd_act_c;
      if (start_c) begin
        VA_o        <= AW'(req_addr);
        FC0         <= req_fc[0];
        FC1         <= req_fc[1];
        we_q        <= req_we;
        uds_q       <= req_uds;
        lds_q       <= req_lds;
        wdata_q     <= req_wdata;
        wait_half_q <= 1'b0;
      end
      if (state_q == ST_S4 && cpu_ce)
        wait_half_q <= !wait_half_q && (state_d == ST_S4);
      if (we_q && state_q == ST_S2 && state_d == ST_S3)
        VD_o <= wdata_q;
      if (!we_q && state_q == ST_S6 && state_d == ST_S7)
        rdata <= timeout_q ? {DW{1'b1}} : VD_i;
    end
  end

`ifdef M68K_BUS_TIMEOUT_EN
  localparam int unsigned WCW = 8;
  logic [WCW-1:0] wait_cnt_q;

  // Wait-state counter: after 255 unanswered waits the cycle is forced to complete with err
  assign timeout_c = DTACK_i && (wait_cnt_q == {WCW{1'b1}});

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= done_c && timeout_q;
      if (start_c) begin
        wait_cnt_q <= '0;
        timeout_q  <= 1'b0;
      end else if (sample_c) begin
        if (timeout_c)    timeout_q  <= 1'b1;
        else if (DTACK_i) wait_cnt_q <= wait_cnt_q + WCW'(1);
      end
    end
  end
`else
  assign timeout_c = 1'b0;
  assign timeout_q = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_m68k_bus_master.sv
// Self-checking bench for m68k_bus_master: scoreboard of expected completions, DTACK responder, arbitration and reset cases.
module tb_m68k_bus_master;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        cpu_ce = 1'b0;
  logic        req = 1'b0;
  logic [22:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic        req_uds = 1'b0;
  logic        req_lds = 1'b0;
  logic [1:0]  req_fc = '0;
  logic [15:0] req_wdata = '0;
  logic        ack, err, busy;
  logic [15:0] rdata;
  logic [22:0] VA_o;
  logic        VA_d;
  logic [15:0] VD_i = '0;
  logic [15:0] VD_o;
  logic        VD_d, AS_o, UDS_o, LDS_o, RW_o, strobe_d, FC0, FC1, BG;
  logic        DTACK_i = 1'b1;
  logic        BR_i = 1'b1;
  logic        BGACK_i = 1'b1;

  m68k_bus_master dut (
    .MCLK(MCLK), .RESET(RESET), .cpu_ce(cpu_ce), .req(req), .req_addr(req_addr),
    .req_we(req_we), .req_uds(req_uds), .req_lds(req_lds), .req_fc(req_fc),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .VA_o(VA_o), .VA_d(VA_d), .VD_i(VD_i), .VD_o(VD_o), .VD_d(VD_d),
    .AS_o(AS_o), .UDS_o(UDS_o), .LDS_o(LDS_o), .RW_o(RW_o), .strobe_d(strobe_d),
    .FC0(FC0), .FC1(FC1), .DTACK_i(DTACK_i), .BR_i(BR_i), .BGACK_i(BGACK_i), .BG(BG)
  );

  always #5 MCLK = ~MCLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // cpu_ce every fourth MCLK; ce_cnt counts the pulses the DUT sees
  int unsigned ce_div = 0;
  int unsigned ce_cnt = 0;
  int unsigned start_ce = 0;
  int unsigned dtack_at = 0;

  always @(negedge MCLK) begin
    ce_div = (ce_div + 1) % 4;
    cpu_ce = (ce_div == 0);
  end

  always @(posedge MCLK) if (cpu_ce && !RESET) ce_cnt++;

  // Slave model: DTACK low once AS is asserted and dtack_at pulses have elapsed since S0
  always @(negedge MCLK)
    DTACK_i = !(AS_o == 1'b0 && (ce_cnt - start_ce) >= dtack_at);

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
    logic [31:0] ce;
  } exp_t;

  exp_t sb[$];
  exp_t got;

  always @(negedge MCLK) begin
    if (ack === 1'b1) begin
      if (sb.size() == 0) chk("spurious_ack", 32'(ack), 32'd0);
      else begin
        got = sb.pop_front();
        chk("ack_rdata", 32'(rdata), 32'(got.rdata));
        chk("ack_err", 32'(err), 32'(got.err));
        chk("ack_latency", ce_cnt - start_ce, got.ce);
      end
    end
  end

  task automatic issue(input logic [22:0] a, input logic we, input logic u, input logic l,
                       input logic [1:0] fc, input logic [15:0] wd, input logic [15:0] vd,
                       input int unsigned dat, input bit push, input logic [15:0] er,
                       input logic ee, input int unsigned ece);
    exp_t e;
    @(negedge MCLK);
    req_addr = a; req_we = we; req_uds = u; req_lds = l; req_fc = fc;
    req_wdata = wd; VD_i = vd; dtack_at = dat; req = 1'b1;
    e.rdata = er; e.err = ee; e.ce = ece;
    if (push) sb.push_back(e);
  endtask

  // Wait for S0 (address bus driven), mark the cycle start and drop req
  task automatic wait_start(input string tag);
    int unsigned n = 0;
    while (VA_d !== 1'b0 && n < 400) begin @(negedge MCLK); n++; end
    chk({tag, "_start"}, 32'(VA_d), 32'd0);
    start_ce = ce_cnt;
    req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge MCLK); n++; end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge MCLK);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctl"}, 32'({AS_o, UDS_o, LDS_o, RW_o, BG, VA_d, VD_d, strobe_d}), 32'h0FE);
    chk({tag, "_flags"}, 32'({FC1, FC0, ack, err, busy}), 32'd0);
    chk({tag, "_va"}, 32'(VA_o), 32'd0);
    chk({tag, "_vd"}, 32'(VD_o), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    repeat (4) @(negedge MCLK);
    check_reset_vals("rst");
    RESET = 1'b0;
    repeat (3) @(negedge MCLK);

    // Zero-wait read
    issue(23'h000100, 1'b0, 1'b1, 1'b1, 2'b01, 16'h0000, 16'h1234, 0, 1'b1, 16'h1234, 1'b0, 8);
    wait_start("rd0");
    chk("rd0_va", 32'(VA_o), 32'h000100);
    chk("rd0_fc", 32'({FC1, FC0}), 32'd1);
    chk("rd0_s0pins", 32'({RW_o, AS_o, UDS_o, LDS_o}), 32'hF);
    wait_idle("rd0", 200);

    // Lower-byte write with three wait states; rdata must hold the previous read
    issue(23'h7F0000, 1'b1, 1'b0, 1'b1, 2'b10, 16'hABCD, 16'h0000, 10, 1'b1, 16'h1234, 1'b0, 14);
    wait_start("wr");
    n = 0;
    while (LDS_o !== 1'b0 && n < 200) begin @(negedge MCLK); n++; end
    chk("wr_lds_at_s4", ce_cnt - start_ce, 32'd4);
    chk("wr_pins", 32'({UDS_o, LDS_o, RW_o, VD_d, AS_o}), 32'h10);
    chk("wr_vd", 32'(VD_o), 32'hABCD);
    wait_idle("wr", 400);
    chk("wr_release", 32'({RW_o, VD_d, VA_d}), 32'h7);

    // Upper-byte read with one wait state
    issue(23'h2AAAAA, 1'b0, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h5A5A, 6, 1'b1, 16'h5A5A, 1'b0, 10);
    wait_start("rd1");
    n = 0;
    while (UDS_o !== 1'b0 && n < 200) begin @(negedge MCLK); n++; end
    chk("rd1_uds_at_s2", ce_cnt - start_ce, 32'd2);
    chk("rd1_lds_idle", 32'(LDS_o), 32'd1);
    wait_idle("rd1", 400);

    // BR wins over a simultaneous req; req stays pending through GRANT/OWNED
    issue(23'h001234, 1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 16'hC0DE, 0, 1'b1, 16'hC0DE, 1'b0, 8);
    BR_i = 1'b0;
    n = 0;
    while (BG !== 1'b0 && n < 50) begin @(negedge MCLK); n++; end
    chk("arb_bg", 32'(BG), 32'd0);
    chk("arb_tristate", 32'({AS_o, VA_d, VD_d, strobe_d, busy}), 32'h1F);
    BGACK_i = 1'b0;
    repeat (12) @(negedge MCLK);
    BR_i = 1'b1;
    repeat (12) @(negedge MCLK);
    chk("arb_owned", 32'({BG, AS_o, strobe_d}), 32'h3);
    BGACK_i = 1'b1;
    wait_start("arb");
    chk("arb_bg_released", 32'(BG), 32'd1);
    wait_idle("arb", 200);

    // Grant withdrawn by BR before BGACK
    @(negedge MCLK);
    BR_i = 1'b0;
    n = 0;
    while (BG !== 1'b0 && n < 50) begin @(negedge MCLK); n++; end
    chk("grant_bg", 32'(BG), 32'd0);
    BR_i = 1'b1;
    wait_idle("grant", 50);
    chk("grant_release", 32'({BG, strobe_d}), 32'h2);

    // Reset during S5 drops the cycle with no ack
    issue(23'h000222, 1'b0, 1'b1, 1'b1, 2'b01, 16'h0000, 16'h1111, 0, 1'b1, 16'h1111, 1'b0, 8);
    wait_start("rs5");
    n = 0;
    while ((ce_cnt - start_ce) < 5 && n < 100) begin @(negedge MCLK); n++; end
    chk("rs5_reach", ce_cnt - start_ce, 32'd5);
    RESET = 1'b1;
    sb.delete();
    @(negedge MCLK);
    check_reset_vals("rs5");
    RESET = 1'b0;
    repeat (40) @(negedge MCLK);
    chk("rs5_quiet", 32'({busy, ack}), 32'd0);

`ifdef M68K_BUS_TIMEOUT_EN
    // No DTACK: 255 waits then forced completion with err and FFFF
    issue(23'h0000AA, 1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 16'h9999, 32'hFFFF_FFFF, 1'b1,
          16'hFFFF, 1'b1, 518);
    wait_start("to");
    wait_idle("to", 3000);
`else
    // No DTACK: cycle waits indefinitely
    issue(23'h0000AA, 1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 16'h9999, 32'hFFFF_FFFF, 1'b0,
          16'h0000, 1'b0, 0);
    wait_start("to");
    repeat (2400) @(negedge MCLK);
    chk("to_hang", 32'({busy, AS_o, ack}), 32'h4);
    RESET = 1'b1;
    @(negedge MCLK);
    RESET = 1'b0;
    @(negedge MCLK);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
